// File: rtl/mda_vram_arbiter.sv
// mda_vram_arbiter: shares the video SRAM between display pixel fetches and
// ISA host memory cycles. Pixel reads always own the bus; a host access is
// captured, held pending and run only inside sequencer ISA windows, with
// isa_rdy stretching the host until the access completes or times out.
module mda_vram_arbiter #(
    parameter int unsigned ACC_CYCLES = 3,
    parameter int unsigned WAIT_MAX   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_read,
    input  logic [18:0] pixel_addr,
    input  logic        isa_op_enable,
    input  logic        isa_read,
    input  logic        isa_write,
    input  logic [18:0] isa_addr,
    input  logic [7:0]  isa_din,
    input  logic [7:0]  ram_din,
    output logic [18:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_oe,
    output logic        ram_we_l,
    output logic [7:0]  pixel_data,
    output logic [7:0]  isa_dout,
    output logic        isa_rdy,
    output logic        timeout
);

    localparam int unsigned PW = $clog2(ACC_CYCLES);
    localparam int unsigned WW = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;
    localparam logic [PW-1:0] PhLast   = PW'(ACC_CYCLES - 1);
    localparam logic [WW-1:0] WaitLast = WW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {StIdle, StPending, StAccess, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [18:0]   addr_q, addr_d, ram_a_q;
    logic [7:0]    din_q, din_d, dout_q, dout_d, pix_q;
    logic          wr_q, wr_d, rdy_q, rdy_d, to_q, to_d, strb_q;
    logic          strobe, window, drive;

    assign strobe = isa_read | isa_write;
    assign window = isa_op_enable & ~pixel_read;
    // Host owns the pins only in an unpreempted ACCESS cycle of a live bus cycle.
    assign drive  = (state_q == StAccess) & window & strobe & ~reset;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b1;
            to_q    <= 1'b0;
            strb_q  <= 1'b0;
            pix_q   <= '0;
            ram_a_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            rdy_q   <= rdy_d;
            to_q    <= to_d;
            strb_q  <= strobe;
            ram_a_q <= ram_a;
            if (pixel_read) begin
                pix_q <= ram_din;
            end
        end
    end

    // Next-state: capture, windowed access, preemption, abort and timeout.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = rdy_q ? '0 : wait_q + 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        wr_d    = wr_q;
        rdy_d   = rdy_q;
        to_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (strobe & ~strb_q) begin
                    addr_d  = isa_addr;
                    din_d   = isa_din;
                    wr_d    = isa_write;  // simultaneous rise counts as a write
                    rdy_d   = 1'b0;
                    state_d = StPending;
                end
            end
            StPending: begin
                if (window) begin
                    state_d = StAccess;
                    phase_d = '0;
                end
            end
            StAccess: begin
                if (!window) begin
                    state_d = StPending;  // whole access is retried later
                end else if (phase_q == PhLast) begin
                    if (!wr_q) begin
                        dout_d = ram_din;
                    end
                    rdy_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StDone: begin
                if (!strobe) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q == StPending || state_q == StAccess) begin
            if (!strobe) begin
                state_d = StIdle;
                rdy_d   = 1'b1;
                dout_d  = dout_q;
            end else if (wait_q == WaitLast && state_d != StDone) begin
                // A completing access on the last allowed cycle beats the timeout.
                state_d = StDone;
                rdy_d   = 1'b1;
                to_d    = 1'b1;
            end
        end
    end

    // SRAM bus steering: pixel fetch first, then host access, else hold address.
    always_comb begin
        ram_a = ram_a_q;
        if (pixel_read) begin
            ram_a = pixel_addr;
        end else if (state_q == StAccess) begin
            ram_a = addr_q;
        end
    end

    assign ram_oe     = drive & wr_q;
    assign ram_we_l   = ~(drive & wr_q & (phase_q != '0) & (phase_q != PhLast));
    assign ram_dout   = din_q;
    assign pixel_data = pix_q;
    assign isa_dout   = dout_q;
    assign isa_rdy    = rdy_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// Bench for mda_vram_arbiter: SRAM model plus a scoreboard. Stimulus computes
// each host cycle's outcome from the window pattern it drives and queues it;
// a negedge monitor compares whenever isa_rdy rises or pixel data is due.
module tb_mda_vram_arbiter;

    localparam int ACC  = 3;
    localparam int WMAX = 20;

    logic        clk, reset, pixel_read, isa_op_enable, isa_read, isa_write;
    logic [18:0] pixel_addr, isa_addr, ram_a;
    logic [7:0]  isa_din, ram_din, ram_dout, pixel_data, isa_dout;
    logic        ram_oe, ram_we_l, isa_rdy, timeout;

    mda_vram_arbiter #(.ACC_CYCLES(ACC), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .reset(reset), .pixel_read(pixel_read), .pixel_addr(pixel_addr),
        .isa_op_enable(isa_op_enable), .isa_read(isa_read), .isa_write(isa_write),
        .isa_addr(isa_addr), .isa_din(isa_din), .ram_din(ram_din), .ram_a(ram_a),
        .ram_dout(ram_dout), .ram_oe(ram_oe), .ram_we_l(ram_we_l),
        .pixel_data(pixel_data), .isa_dout(isa_dout), .isa_rdy(isa_rdy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: host addresses live in 0..511, pixel fetches in 512..1023.
    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    int         wr_count = 0;
    assign ram_din = mem[ram_a[9:0]];
    always @(posedge clk) begin
        if (!ram_we_l) begin
            mem[ram_a[9:0]] <= ram_dout;
            wr_count = wr_count + 1;
        end
    end

    typedef struct {
        bit          wr;
        logic [18:0] addr;
        logic [7:0]  data;
        int          waitc;
        bit          to;
        int          writes;
    } exp_t;

    exp_t       hq[$];
    logic [7:0] pq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops scoreboard entries when the DUT presents results.
    bit   rdy_prev = 1'b1, pix_prev = 1'b0, after_rise = 1'b0;
    int   low_cnt = 0, wr_snap = 0;
    always @(negedge clk) begin
        if (reset) begin
            rdy_prev = 1'b1;
            pix_prev = 1'b0;
            after_rise = 1'b0;
        end else begin
            if (!ram_we_l) check("we_l_guard", {pixel_read, ram_oe}, 2'b01);
            if (pix_prev) begin
                if (pq.size() == 0) check("pixel_queue", 1, 0);
                else check("pixel_data", pixel_data, pq.pop_front());
            end
            pix_prev = pixel_read;
            if (!isa_rdy) begin
                if (rdy_prev) begin
                    low_cnt = 0;
                    wr_snap = wr_count;
                end
                low_cnt++;
            end else if (!rdy_prev) begin
                if (hq.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = hq.pop_front();
                    check("rdy_low_cycles", low_cnt, e.waitc);
                    check("timeout_pulse", timeout, e.to);
                    check("sram_writes", wr_count - wr_snap, e.writes);
                    if (e.wr) check("sram_byte", mem[e.addr[9:0]], e.data);
                    else      check("isa_dout", isa_dout, e.data);
                end
                after_rise = 1'b1;
            end else if (after_rise) begin
                check("timeout_one_cycle", timeout, 0);
                after_rise = 1'b0;
            end
            rdy_prev = isa_rdy;
        end
    end

    // One host bus cycle. Cycle 0 raises the strobe; cycle i<plen drives
    // pixbits[i]/enbits[i]; later cycles leave the window open unless never.
    task automatic host_txn(input bit wr, input logic [18:0] a, input logic [7:0] d,
                            input int plen, input logic [31:0] pixbits,
                            input logic [31:0] enbits, input bit never, input int hold);
        bit   win [0:63];
        int   run = 0, end_idx = -1, extra = 0, snap;
        bit   done = 1'b0;
        exp_t e;
        for (int i = 0; i < 64; i++)
            win[i] = (i < plen) ? (enbits[i] & ~pixbits[i]) : ~never;
        // Access needs ACC+1 consecutive window cycles (one pending + ACC access);
        // an interrupted run of 3+ already strobed once.
        for (int i = 1; i <= WMAX; i++) begin
            if (win[i]) run++;
            else begin
                if (run >= 3) extra++;
                run = 0;
            end
            if (run == ACC + 1) begin
                end_idx = i;
                break;
            end
        end
        if (end_idx < 0 && run >= 3) extra++;
        e.wr = wr;
        e.addr = a;
        e.to = (end_idx < 0);
        e.waitc = e.to ? WMAX : end_idx;
        e.writes = wr ? extra + (e.to ? 0 : 1) : 0;
        if (wr) begin
            if (!e.to) ref_mem[a[9:0]] = d;
            e.data = ref_mem[a[9:0]];
        end else begin
            if (!e.to) last_rd = ref_mem[a[9:0]];
            e.data = last_rd;
        end
        hq.push_back(e);
        for (int i = 0; i < plen + 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                isa_addr  = a;
                isa_din   = d;
                isa_write = wr;
                isa_read  = ~wr;
            end
            pixel_read    = (i < plen) ? pixbits[i] : 1'b0;
            isa_op_enable = (i < plen) ? enbits[i] : ~never;
            pixel_addr    = 19'(512 + $urandom_range(511));
            if (pixel_read) pq.push_back(ref_mem[pixel_addr[9:0]]);
            @(negedge clk);
            if (i >= 1 && isa_rdy) done = 1'b1;
        end
        if (!done) check("ready_bound", 0, 1);
        @(posedge clk);
        #1;
        pixel_read = 1'b0;
        isa_op_enable = 1'b0;
        snap = wr_count;
        repeat (hold) @(posedge clk);
        #1;
        isa_write = 1'b0;
        isa_read  = 1'b0;
        repeat (2) @(posedge clk);
        if (hold > 0) check("held_strobe_writes", wr_count - snap, 0);
    endtask

    initial begin
        int wsnap;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        reset = 1'b1;
        pixel_read = 1'b0;
        pixel_addr = '0;
        isa_op_enable = 1'b0;
        isa_read = 1'b0;
        isa_write = 1'b0;
        isa_addr = '0;
        isa_din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_a", ram_a, 0);
        check("rst_ram_dout", ram_dout, 0);
        check("rst_ram_oe", ram_oe, 0);
        check("rst_ram_we_l", ram_we_l, 1);
        check("rst_pixel_data", pixel_data, 0);
        check("rst_isa_dout", isa_dout, 0);
        check("rst_isa_rdy", isa_rdy, 1);
        check("rst_timeout", timeout, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        host_txn(1, 19'h00123, 8'h5A, 0, 0, 0, 0, 0);          // clean write
        host_txn(0, 19'h00123, 8'h00, 10, 32'h3FF, $urandom, 0, 0); // read behind pixels
        host_txn(1, 19'h00077, 8'hC3, 4, 32'h8, 32'hF, 0, 0);  // preempt in phase 1
        host_txn(1, 19'h00078, 8'h3C, 5, 32'h10, 32'h1F, 0, 0); // preempt in hold
        host_txn(0, 19'h00078, 8'h00, 0, 0, 0, 0, 0);
        host_txn(1, 19'h00099, 8'hEE, 0, 0, 0, 1, 0);          // window never opens
        host_txn(0, 19'h00099, 8'h00, 0, 0, 0, 1, 0);
        host_txn(1, 19'h00100, 8'h11, 0, 0, 0, 0, 50);         // strobe held in DONE
        host_txn(1, 19'h00100, 8'h22, 0, 0, 0, 0, 0);

        // Reset landing on ACCESS phase 1 of a write.
        @(posedge clk);
        #1;
        isa_addr = 19'h00040;
        isa_din = ~ref_mem[10'h040];
        isa_write = 1'b1;
        isa_op_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_we_l", ram_we_l, 0);
        wsnap = wr_count;
        reset = 1'b1;
        #1;
        check("reset_we_l_now", ram_we_l, 1);
        check("reset_oe_now", ram_oe, 0);
        @(posedge clk);
        #1;
        isa_write = 1'b0;
        isa_op_enable = 1'b0;
        @(negedge clk);
        check("after_reset_we_l", ram_we_l, 1);
        check("after_reset_oe", ram_oe, 0);
        check("after_reset_rdy", isa_rdy, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_rd = 8'h00;
        @(negedge clk);
        check("reset_no_write", wr_count - wsnap, 0);
        check("reset_sram_kept", mem[10'h040], ref_mem[10'h040]);
        repeat (2) @(posedge clk);

        for (int t = 0; t < 40; t++) begin
            host_txn(1'($urandom), 19'($urandom_range(511)), 8'($urandom),
                     $urandom_range(12), $urandom & $urandom, $urandom | $urandom,
                     0, $urandom_range(2));
        end
        repeat (3) @(posedge clk);
        check("scoreboard_drained", hq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mda_vram_arbiter.md
# mda_vram_arbiter

Shares the single video SRAM between the display fetch path (pixel reads issued by the sequencer) and ISA host memory cycles. Pixel reads always win the bus; ISA reads and writes are captured, held pending, and executed only inside sequencer-provided ISA windows. The host is stretched through an IOCHRDY-style ready output until its access completes. It sits between the ISA decode/sync logic, the sequencer, and the SRAM pins, replacing the ad-hoc bus steering in the VRAM interface.

## Interface
Parameters:
- ACC_CYCLES, 3: SRAM cycles per ISA access (setup, strobe, hold/sample); minimum 3.
- WAIT_MAX, 255: max clk cycles isa_rdy may stay low before forced release.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pixel_read  in  1  sequencer display fetch strobe; absolute priority.
- pixel_addr  in  19  display fetch address.
- isa_op_enable  in  1  sequencer ISA window; high ≥ ACC_CYCLES consecutive cycles.
- isa_read  in  1  synced host memory read (level, held for whole bus cycle).
- isa_write  in  1  synced host memory write (level).
- isa_addr  in  19  host address, stable while strobe high.
- isa_din  in  8  host write data.
- ram_din  in  8  SRAM data pins (input side).
- ram_a  out  19  SRAM address.
- ram_dout  out  8  SRAM write data.
- ram_oe  out  1  drive enable for ram_dout onto SRAM pins.
- ram_we_l  out  1  SRAM write strobe, active low.
- pixel_data  out  8  registered SRAM data for display path.
- isa_dout  out  8  registered host read data.
- isa_rdy  out  1  host ready; low = insert wait states.
- timeout  out  1  one-cycle pulse when WAIT_MAX forces release.

## Operation
- States: IDLE, PENDING, ACCESS, DONE.
- IDLE: rising edge of (isa_read | isa_write) (vs. previous cycle) latches addr, din, dir → PENDING; isa_rdy drops the same edge.
- PENDING: when isa_op_enable & ~pixel_read → ACCESS, phase counter = 0.
- ACCESS phases: 0 addr/data setup (ram_oe=1 on write, we_l=1); 1..ACC_CYCLES-2 strobe (we_l=0 on write); ACC_CYCLES-1 hold (we_l=1, ram_oe still 1 on write; read samples ram_din into isa_dout). Then → DONE.
- Preemption: pixel_read or ~isa_op_enable during ACCESS → we_l=1, ram_oe=0 immediately, back to PENDING; full access retried (rewrite idempotent).
- DONE: isa_rdy=1; stay until both strobes low, then → IDLE. One access per host bus cycle; a held strobe never retriggers.
- Bus mux: pixel_read → ram_a=pixel_addr, we_l=1, ram_oe=0; else in ACCESS → latched ISA addr; else ram_a holds last value, we_l=1, ram_oe=0.
- Timeout: 8-bit-min counter runs while isa_rdy low; at WAIT_MAX → isa_rdy=1, timeout pulse, state → DONE (access abandoned, isa_dout unchanged).
- Strobe dropped while PENDING/ACCESS (host abort) → IDLE, no write performed if in PENDING, isa_rdy=1.
- Simultaneous isa_read and isa_write rising: treated as write.

## Timing
- Reset: state IDLE, ram_a=0, ram_dout=0, ram_oe=0, ram_we_l=1, pixel_data=0, isa_dout=0, isa_rdy=1, timeout=0, counters 0.
- pixel_data: ram_din registered 1 cycle after any cycle with pixel_read=1; otherwise holds.
- isa_rdy low on the cycle after strobe rise; best-case high again ACC_CYCLES+1 cycles after entering PENDING with window open.
- isa_dout valid no later than the cycle isa_rdy rises; holds until next read completes.
- ram_we_l never low in a cycle with pixel_read=1 or ram_oe=0.

## Test plan
- Reset mid-ACCESS write (phase 1): next cycle we_l=1, ram_oe=0, isa_rdy=1, state IDLE; SRAM model unchanged after reset.
- Write 0x5A to 0x00123 with window open, no pixel reads → we_l low exactly 1 cycle (ACC_CYCLES=3), SRAM[0x123]=0x5A, isa_rdy low 4 cycles.
- Read with pixel_read asserted every cycle for 10 cycles, then window → isa_rdy stays low throughout, pixel_data tracks SRAM per cycle, isa_dout = SRAM byte after window.
- pixel_read asserted in ACCESS phase 1 of write → we_l released same cycle, retried in next window, final SRAM value correct, written once more.
- isa_op_enable held low, WAIT_MAX=20 → timeout pulses at 20 wait cycles, isa_rdy=1, no SRAM write.
- Strobe held 50 cycles after DONE → exactly one SRAM access; new rising edge starts a second.
